// File: rtl/team_04_pkg.sv
// Shared types and helpers for the team_04 4x4 keypad scanner.
// Key codes are row_idx*4 + col_idx, which is simply {row_idx, col_idx}.
package team_04_pkg;

    localparam int KEY_CODE_W = 4;
    localparam int KEYPAD_N   = 4;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DEBOUNCE,
        HELD
    } scan_state_t;

    function automatic logic [1:0] onehot_idx(input logic [KEYPAD_N-1:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < KEYPAD_N; i++) begin
            if (v[i]) begin
                idx = i[1:0];
            end
        end
        return idx;
    endfunction

    function automatic logic is_onehot(input logic [KEYPAD_N-1:0] v);
        return (v != '0) && ((v & (v - 4'd1)) == '0);
    endfunction

endpackage

// File: rtl/team_04_sync2.sv
// Two-flop synchronizer for asynchronous level inputs.
// Both stages clear on reset so downstream logic starts from a known zero.
module team_04_sync2 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/team_04_keypad_scanner.sv
// 4x4 keypad scanner: rotates a one-hot column drive, debounces press and
// release on the synchronized rows, and reports accepted keys as a pulse.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   IDLE     | en low or just out of reset; col = 0, nothing latched
//   SCAN     | column rotates every CLK_DIV cycles, row sampled on last
//   DEBOUNCE | column held, latched row must stay stable for the window
//   HELD     | key accepted; waits for a stable all-zero release window
module team_04_keypad_scanner
    import team_04_pkg::*;
#(
    parameter int CLK_DIV         = 40000,
    parameter int DEBOUNCE_CYCLES = 400000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [3:0]            row,
    output logic [3:0]            col,
    output logic                  key_valid,
    output logic [KEY_CODE_W-1:0] key_code,
    output logic                  key_held
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(CLK_DIV - 1);
    localparam logic [BW-1:0] DEB_LAST   = BW'(DEBOUNCE_CYCLES - 1);

    logic [3:0] row_s;

    team_04_sync2 #(.WIDTH(4)) u_row_sync (
        .clk (clk),
        .rst (rst),
        .d   (row),
        .q   (row_s)
    );

    scan_state_t           state, state_n;
    logic [3:0]            col_n;
    logic [DW-1:0]         dwell_cnt, dwell_n;
    logic [BW-1:0]         deb_cnt, deb_n;
    logic [3:0]            lat_row, lat_row_n;
    logic [1:0]            lat_col, lat_col_n;
    logic                  valid_n;
    logic [KEY_CODE_W-1:0] code_n;
    logic                  held_n;
    logic [3:0]            col_next;

    assign col_next = {col[2:0], col[3]};

    always_comb begin
        state_n   = state;
        col_n     = col;
        dwell_n   = dwell_cnt;
        deb_n     = deb_cnt;
        lat_row_n = lat_row;
        lat_col_n = lat_col;
        valid_n   = 1'b0;
        code_n    = key_code;
        held_n    = key_held;

        if (!en) begin
            state_n = IDLE;
            col_n   = '0;
            dwell_n = '0;
            deb_n   = '0;
            held_n  = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state_n = SCAN;
                    col_n   = 4'b0001;
                    dwell_n = '0;
                    deb_n   = '0;
                    held_n  = 1'b0;
                end
                SCAN: begin
                    if (dwell_cnt == DWELL_LAST) begin
                        // Only a single pressed row is unambiguous; ghosting patterns are dropped.
                        if (is_onehot(row_s)) begin
                            lat_row_n = row_s;
                            lat_col_n = onehot_idx(col);
                            deb_n     = '0;
                            state_n   = DEBOUNCE;
                        end else begin
                            col_n   = col_next;
                            dwell_n = '0;
                        end
                    end else begin
                        dwell_n = dwell_cnt + DW'(1);
                    end
                end
                DEBOUNCE: begin
                    if (row_s != lat_row) begin
                        state_n = SCAN;
                        col_n   = col_next;
                        dwell_n = '0;
                        deb_n   = '0;
                    end else if (deb_cnt == DEB_LAST) begin
                        valid_n = 1'b1;
                        code_n  = {onehot_idx(lat_row), lat_col};
                        held_n  = 1'b1;
                        deb_n   = '0;
                        state_n = HELD;
                    end else begin
                        deb_n = deb_cnt + BW'(1);
                    end
                end
                HELD: begin
                    if (row_s != '0) begin
                        deb_n = '0;
                    end else if (deb_cnt == DEB_LAST) begin
                        state_n = SCAN;
                        col_n   = col_next;
                        dwell_n = '0;
                        deb_n   = '0;
                        held_n  = 1'b0;
                    end else begin
                        deb_n = deb_cnt + BW'(1);
                    end
                end
                default: begin
                    state_n = IDLE;
                    col_n   = '0;
                    dwell_n = '0;
                    deb_n   = '0;
                    held_n  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            col       <= '0;
            dwell_cnt <= '0;
            deb_cnt   <= '0;
            lat_row   <= '0;
            lat_col   <= '0;
            key_valid <= 1'b0;
            key_code  <= '0;
            key_held  <= 1'b0;
        end else begin
            state     <= state_n;
            col       <= col_n;
            dwell_cnt <= dwell_n;
            deb_cnt   <= deb_n;
            lat_row   <= lat_row_n;
            lat_col   <= lat_col_n;
            key_valid <= valid_n;
            key_code  <= code_n;
            key_held  <= held_n;
        end
    end

endmodule

// File: tb/tb_team_04_keypad_scanner.sv
// Self-checking bench for team_04_keypad_scanner with CLK_DIV=4, DEBOUNCE_CYCLES=8.
// Expected key codes are queued when a press is driven and popped on key_valid.
module tb_team_04_keypad_scanner;

    localparam int CLK_DIV = 4;
    localparam int DEB     = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [3:0] row;
    logic [3:0] col;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_held;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [3:0] exp_q[$];
    logic [3:0] mon_exp;

    always #5 clk = ~clk;

    team_04_keypad_scanner #(
        .CLK_DIV         (CLK_DIV),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .row       (row),
        .col       (col),
        .key_valid (key_valid),
        .key_code  (key_code),
        .key_held  (key_held)
    );

    task automatic wait_col(input logic [3:0] c, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (col === c) begin
                ok = 1'b1;
                return;
            end
        end
        n_checks++;
        n_fail++;
        $display("FAIL wait_col: col=%b, required %b within 64 cycles", col, c);
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (key_valid === 1'b1) begin
                ok = 1'b1;
                return;
            end
        end
        n_checks++;
        n_fail++;
        $display("FAIL wait_valid: key_valid=%b, required a pulse within 64 cycles", key_valid);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        en  = 1'b0;
        row = 4'b0000;
        repeat (3) @(negedge clk);
        n_checks++;
        if (col !== 4'b0000) begin n_fail++; $display("FAIL reset_col: got %b, required 0000", col); end
        n_checks++;
        if (key_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b, required 0", key_valid); end
        n_checks++;
        if (key_code !== 4'd0) begin n_fail++; $display("FAIL reset_code: got %0d, required 0", key_code); end
        n_checks++;
        if (key_held !== 1'b0) begin n_fail++; $display("FAIL reset_held: got %b, required 0", key_held); end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (col !== 4'b0000) begin n_fail++; $display("FAIL idle_col: got %b, required 0000 with en low", col); end
    endtask

    task automatic test_scan_rotation();
        logic [3:0] exp;
        en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            exp = 4'b0001 << (i / CLK_DIV);
            n_checks++;
            if (col !== exp) begin
                n_fail++;
                $display("FAIL scan_col[%0d]: got %b, required %b", i, col, exp);
            end
        end
    endtask

    task automatic test_press();
        bit ok;
        wait_col(4'b0010, ok);
        row = 4'b0100;
        exp_q.push_back(4'd9);
        wait_valid(ok);
        if (ok) begin
            n_checks++;
            if (key_held !== 1'b1) begin n_fail++; $display("FAIL press_held_at_pulse: got %b, required 1", key_held); end
            n_checks++;
            if (col !== 4'b0010) begin n_fail++; $display("FAIL press_col_hold: got %b, required 0010", col); end
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (key_held !== 1'b1) begin n_fail++; $display("FAIL press_held: got %b, required 1", key_held); end
        row = 4'b0000;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            n_checks++;
            if (key_held !== 1'b1) begin
                n_fail++;
                $display("FAIL release_held[%0d]: got %b, required 1", i, key_held);
            end
        end
        @(negedge clk);
        n_checks++;
        if (key_held !== 1'b0) begin n_fail++; $display("FAIL release_done_held: got %b, required 0", key_held); end
        n_checks++;
        if (col !== 4'b0100) begin n_fail++; $display("FAIL release_resume_col: got %b, required 0100", col); end
    endtask

    task automatic test_short_press();
        bit ok;
        int cnt;
        wait_col(4'b1000, ok);
        row = 4'b0001;
        cnt = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (col === 4'b1000) cnt++;
        end
        row = 4'b0000;
        for (int i = 0; i < 20 && col === 4'b1000; i++) begin
            @(negedge clk);
            if (col === 4'b1000) cnt++;
        end
        n_checks++;
        if (cnt != 8) begin n_fail++; $display("FAIL short_dwell: col=1000 for %0d cycles, required 8", cnt); end
        n_checks++;
        if (col !== 4'b0001) begin n_fail++; $display("FAIL short_resume_col: got %b, required 0001", col); end
        n_checks++;
        if (key_held !== 1'b0) begin n_fail++; $display("FAIL short_held: got %b, required 0", key_held); end
    endtask

    task automatic test_multi_hot();
        bit ok;
        logic [3:0] exp;
        wait_col(4'b0010, ok);
        row = 4'b0011;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            exp = 4'b0001 << ((1 + i / CLK_DIV) % 4);
            n_checks++;
            if (col !== exp) begin
                n_fail++;
                $display("FAIL multi_col[%0d]: got %b, required %b", i, col, exp);
            end
        end
        row = 4'b0000;
        n_checks++;
        if (key_code !== 4'd9) begin n_fail++; $display("FAIL multi_code_kept: got %0d, required 9", key_code); end
        n_checks++;
        if (key_held !== 1'b0) begin n_fail++; $display("FAIL multi_held: got %b, required 0", key_held); end
    endtask

    task automatic test_en_drop();
        bit ok;
        wait_col(4'b0100, ok);
        row = 4'b0001;
        exp_q.push_back(4'd2);
        wait_valid(ok);
        repeat (2) @(negedge clk);
        n_checks++;
        if (key_held !== 1'b1) begin n_fail++; $display("FAIL endrop_pre_held: got %b, required 1", key_held); end
        en  = 1'b0;
        row = 4'b0000;
        @(negedge clk);
        n_checks++;
        if (col !== 4'b0000) begin n_fail++; $display("FAIL endrop_col: got %b, required 0000", col); end
        n_checks++;
        if (key_held !== 1'b0) begin n_fail++; $display("FAIL endrop_held: got %b, required 0", key_held); end
        n_checks++;
        if (key_code !== 4'd2) begin n_fail++; $display("FAIL endrop_code_kept: got %0d, required 2", key_code); end
        repeat (4) @(negedge clk);
        n_checks++;
        if (col !== 4'b0000) begin n_fail++; $display("FAIL endrop_idle_col: got %b, required 0000", col); end
        en = 1'b1;
        @(negedge clk);
        n_checks++;
        if (col !== 4'b0001) begin n_fail++; $display("FAIL enreturn_col: got %b, required 0001", col); end
    endtask

    task automatic test_rst_debounce();
        bit ok;
        wait_col(4'b0010, ok);
        row = 4'b1000;
        repeat (6) @(negedge clk);
        n_checks++;
        if (col !== 4'b0010) begin n_fail++; $display("FAIL rstdeb_pre_col: got %b, required 0010", col); end
        rst = 1'b1;
        #1;
        n_checks++;
        if (col !== 4'b0000) begin n_fail++; $display("FAIL rstdeb_col: got %b, required 0000", col); end
        n_checks++;
        if (key_valid !== 1'b0) begin n_fail++; $display("FAIL rstdeb_valid: got %b, required 0", key_valid); end
        n_checks++;
        if (key_code !== 4'd0) begin n_fail++; $display("FAIL rstdeb_code: got %0d, required 0", key_code); end
        n_checks++;
        if (key_held !== 1'b0) begin n_fail++; $display("FAIL rstdeb_held: got %b, required 0", key_held); end
        row = 4'b0000;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (col !== 4'b0001) begin n_fail++; $display("FAIL rstdeb_restart_col: got %b, required 0001", col); end
        repeat (40) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        row = 4'b0000;
        fork
            forever begin
                @(negedge clk);
                if (key_valid === 1'b1) begin
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL key_valid_unexpected: pulse with code %0d, required no pulse", key_code);
                    end else begin
                        mon_exp = exp_q.pop_front();
                        if (key_code !== mon_exp) begin
                            n_fail++;
                            $display("FAIL key_code: got %0d, required %0d", key_code, mon_exp);
                        end
                    end
                end
            end
        join_none

        test_reset();
        test_scan_rotation();
        test_press();
        test_short_press();
        test_multi_hot();
        test_en_drop();
        test_rst_debounce();

        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_leftover: %0d keys never reported, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
